// File: rtl/fir_mac_scheduler.sv
// Round-robin scheduler that time-shares one Q-format multiply-accumulate engine between FIR channels.
// Define FIR_MAC_SAT_EN to make the accumulator saturate instead of wrapping modulo 2^DATA_WIDTH.
module fir_mac_scheduler #(
    parameter int  NUM_REQ    = 2,
    parameter int  TAP_NUMBER = 32,
    parameter int  DATA_WIDTH = 32,
    parameter int  FRAC_BITS  = 10,
    localparam int IDX_W      = $clog2(TAP_NUMBER),
    localparam int PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [IDX_W-1:0]              tap_idx,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] tap_coeff,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] tap_sample,
    output logic                          res_valid,
    output logic [DATA_WIDTH-1:0]         res_data,
    input  logic                          res_ack,
    output logic                          busy
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(TAP_NUMBER - 1);

    state_t                  r_state;
    state_t                  w_nextState;
    logic [NUM_REQ-1:0]      r_gnt;
    logic [PTR_W-1:0]        r_ptr;
    logic [PTR_W-1:0]        r_selIdx;
    logic [IDX_W-1:0]        r_tapIdx;
    logic                    r_lastIssued;
    logic                    r_prodValid;
    logic [DATA_WIDTH-1:0]   r_term;
    logic [DATA_WIDTH-1:0]   r_acc;
    logic [DATA_WIDTH-1:0]   r_resData;
    logic                    r_resValid;

    logic [PTR_W-1:0]        w_selIdx;
    logic [NUM_REQ-1:0]      w_gntNext;
    logic [PTR_W-1:0]        w_ptrNext;
    logic [DATA_WIDTH-1:0]   w_coeff;
    logic [DATA_WIDTH-1:0]   w_sample;
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic [DATA_WIDTH-1:0]   w_term;
    logic [DATA_WIDTH-1:0]   w_accSum;

    assign gnt       = r_gnt;
    assign tap_idx   = r_tapIdx;
    assign res_valid = r_resValid;
    assign res_data  = r_resData;
    assign busy      = (r_state != IDLE);

    // First requesting lane at or above the pointer, wrapping around.
    always_comb begin
        int idx;
        logic found;
        idx      = 0;
        found    = 1'b0;
        w_selIdx = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(r_ptr) + off;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                w_selIdx = PTR_W'(idx);
            end
        end
        w_gntNext = NUM_REQ'(1) << w_selIdx;
    end

    assign w_ptrNext = (int'(r_selIdx) == NUM_REQ - 1) ? '0 : r_selIdx + 1'b1;

    assign w_coeff  = tap_coeff[int'(r_selIdx)*DATA_WIDTH +: DATA_WIDTH];
    assign w_sample = tap_sample[int'(r_selIdx)*DATA_WIDTH +: DATA_WIDTH];
    assign w_prod   = $signed(w_coeff) * $signed(w_sample);
    assign w_term   = w_prod[FRAC_BITS +: DATA_WIDTH];

`ifdef FIR_MAC_SAT_EN
    // Overflow only when both operands share a sign and the sum flips it.
    always_comb begin
        logic [DATA_WIDTH-1:0] rawSum;
        rawSum   = r_acc + r_term;
        w_accSum = rawSum;
        if ((r_acc[DATA_WIDTH-1] == r_term[DATA_WIDTH-1]) &&
            (rawSum[DATA_WIDTH-1] != r_acc[DATA_WIDTH-1])) begin
            w_accSum = r_acc[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                           : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end
`else
    assign w_accSum = r_acc + r_term;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (|req) w_nextState = RUN;
            RUN:     if (r_lastIssued) w_nextState = DRAIN;
            DRAIN:   w_nextState = DONE;
            DONE:    if (res_ack) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // RUN spends one extra cycle after the last issue so the final product reaches the accumulator.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_gnt        <= '0;
            r_ptr        <= '0;
            r_selIdx     <= '0;
            r_tapIdx     <= '0;
            r_lastIssued <= 1'b0;
            r_prodValid  <= 1'b0;
            r_term       <= '0;
            r_acc        <= '0;
            r_resData    <= '0;
            r_resValid   <= 1'b0;
        end else begin
            r_prodValid <= 1'b0;
            if (r_prodValid) r_acc <= w_accSum;
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_gnt        <= w_gntNext;
                        r_selIdx     <= w_selIdx;
                        r_acc        <= '0;
                        r_tapIdx     <= '0;
                        r_lastIssued <= 1'b0;
                    end
                end
                RUN: begin
                    if (!r_lastIssued) begin
                        r_term      <= w_term;
                        r_prodValid <= 1'b1;
                        if (r_tapIdx == LAST_TAP) r_lastIssued <= 1'b1;
                        else                      r_tapIdx     <= r_tapIdx + 1'b1;
                    end
                end
                DRAIN: begin
                    r_resData  <= r_acc;
                    r_resValid <= 1'b1;
                end
                DONE: begin
                    if (res_ack) begin
                        r_resValid <= 1'b0;
                        r_gnt      <= '0;
                        r_ptr      <= w_ptrNext;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed self-checking bench for fir_mac_scheduler with the default parameters (2 lanes, 32 taps, Q10).
module tb_fir_mac_scheduler;

    localparam int NR  = 2;
    localparam int DW  = 32;
    localparam int LAT = 34;

    logic              clock;
    logic              reset_n;
    logic [NR-1:0]     req;
    logic [NR-1:0]     gnt;
    logic [4:0]        tap_idx;
    logic [NR*DW-1:0]  tap_coeff;
    logic [NR*DW-1:0]  tap_sample;
    logic              res_valid;
    logic [DW-1:0]     res_data;
    logic              res_ack;
    logic              busy;

    int checks   = 0;
    int failures = 0;
    int mode     = 0;

    fir_mac_scheduler dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req        (req),
        .gnt        (gnt),
        .tap_idx    (tap_idx),
        .tap_coeff  (tap_coeff),
        .tap_sample (tap_sample),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_ack    (res_ack),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Coefficient/sample sources: 0 = 1.0 x tap index, 1 = -3 x -1024, 2 = max positive x max positive.
    always_comb begin
        tap_coeff  = '0;
        tap_sample = '0;
        for (int l = 0; l < NR; l++) begin
            case (mode)
                0: begin
                    tap_coeff[l*DW +: DW]  = 32'd1024;
                    tap_sample[l*DW +: DW] = {27'd0, tap_idx};
                end
                1: begin
                    tap_coeff[l*DW +: DW]  = 32'hFFFF_FFFD;
                    tap_sample[l*DW +: DW] = 32'hFFFF_FC00;
                end
                default: begin
                    tap_coeff[l*DW +: DW]  = 32'h7FFF_FFFF;
                    tap_sample[l*DW +: DW] = 32'h7FFF_FFFF;
                end
            endcase
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NR-1:0] newReq, input int newMode);
        req  = newReq;
        mode = newMode;
    endtask

    task automatic waitGrant();
        int n;
        n = 0;
        while (gnt == '0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        checkOutput("gntTimeout", 32'(n < 50), 32'd1);
    endtask

    task automatic waitResult(input bit earlyAck, output int n);
        n = 0;
        while (!res_valid && n < 100) begin
            if (earlyAck) res_ack = (n < 3);
            @(negedge clock);
            n++;
        end
        res_ack = 1'b0;
    endtask

    task automatic runJob(input logic [NR-1:0] expGnt, input logic [31:0] expRes, input bit earlyAck);
        int n;
        waitGrant();
        checkOutput("gnt", 32'(gnt), 32'(expGnt));
        waitResult(earlyAck, n);
        checkOutput("latency", 32'(n), 32'(LAT));
        checkOutput("resData", res_data, expRes);
        res_ack = 1'b1;
        @(negedge clock);
        res_ack = 1'b0;
        checkOutput("validDrop", 32'(res_valid), 32'd0);
        checkOutput("gntDrop", 32'(gnt), 32'd0);
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        res_ack = 1'b0;
        applyStimulus(2'b00, 0);
        repeat (2) @(negedge clock);
        checkOutput("rstGnt", 32'(gnt), 32'd0);
        checkOutput("rstTap", 32'(tap_idx), 32'd0);
        checkOutput("rstValid", 32'(res_valid), 32'd0);
        checkOutput("rstData", res_data, 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // Single job on lane 0, then a 20-cycle ack stall with both lanes requesting.
        applyStimulus(2'b01, 0);
        waitGrant();
        checkOutput("singleGnt", 32'(gnt), 32'h1);
        checkOutput("singleBusy", 32'(busy), 32'd1);
        waitResult(1'b0, n);
        checkOutput("singleLatency", 32'(n), 32'(LAT));
        checkOutput("singleData", res_data, 32'd496);
        checkOutput("singleTap", 32'(tap_idx), 32'd31);
        applyStimulus(2'b11, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            checkOutput("stallValid", 32'(res_valid), 32'd1);
            checkOutput("stallData", res_data, 32'd496);
            checkOutput("stallGnt", 32'(gnt), 32'h1);
            checkOutput("stallTap", 32'(tap_idx), 32'd31);
        end
        res_ack = 1'b1;
        @(negedge clock);
        res_ack = 1'b0;
        checkOutput("ackValid", 32'(res_valid), 32'd0);
        checkOutput("ackGnt", 32'(gnt), 32'd0);
        checkOutput("ackBusy", 32'(busy), 32'd0);

        // Round-robin with both lanes held high; pointer now favours lane 1.
        runJob(2'b10, 32'd496, 1'b0);
        runJob(2'b01, 32'd496, 1'b0);
        runJob(2'b10, 32'd496, 1'b0);
        runJob(2'b01, 32'd496, 1'b0);

        // Negative operands, with a stray ack during RUN that must be ignored.
        applyStimulus(2'b11, 1);
        runJob(2'b10, 32'd96, 1'b1);

        // Saturating-size products: each term is 0xFFC00000, 32 of them wrap to 0xF8000000.
        applyStimulus(2'b11, 2);
        runJob(2'b01, 32'hF800_0000, 1'b0);

        // Reset in the middle of RUN; pointer returns to 0 afterwards.
        applyStimulus(2'b01, 0);
        waitGrant();
        checkOutput("abortGnt", 32'(gnt), 32'h1);
        n = 0;
        while (tap_idx != 5'd10 && n < 50) begin
            @(negedge clock);
            n++;
        end
        checkOutput("tapTimeout", 32'(n < 50), 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("abortGntZero", 32'(gnt), 32'd0);
        checkOutput("abortTap", 32'(tap_idx), 32'd0);
        checkOutput("abortValid", 32'(res_valid), 32'd0);
        checkOutput("abortData", res_data, 32'd0);
        checkOutput("abortBusy", 32'(busy), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        applyStimulus(2'b10, 0);
        runJob(2'b10, 32'd496, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
